// File: rtl/regfile_scoreboard_pkg.sv
// rtl/regfile_scoreboard_pkg.sv - shared constants and types for the register file slice
package rf_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 2;
    localparam int DEF_CNT_W  = 2;

    // Hard-wired zero register; never stored, never reserved.
    localparam logic [DEF_ADDR_W-1:0] REG_ZERO = '0;

    typedef logic [DEF_CNT_W-1:0] cnt_t;
endpackage

// File: rtl/regfile_scoreboard_if.sv
// rtl/regfile_scoreboard_if.sv - read/write/reserve bus between pipeline and register file
interface regfile_scoreboard_if
    import rf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     rsv_en;
    logic [ADDR_W-1:0]        rsv_addr;
    logic                     rsv_ready;
    logic                     wr_underflow;

    // Pipeline side: decode/issue/writeback
    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        input  rd_data, rd_busy, rsv_ready, wr_underflow
    );

    // Register file side
    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        output rd_data, rd_busy, rsv_ready, wr_underflow
    );
endinterface

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register pending-write counters with reserve/release
module reg_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic                   rsv_en,
    input  logic [ADDR_W-1:0]      rsv_addr,
    output logic                   rsv_ready,
    output logic                   wr_underflow,
    output logic [2**ADDR_W-1:0]   busy_next
);
    localparam int                DEPTH   = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A  = ADDR_W'(REG_ZERO);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q [DEPTH];
    logic [CNT_W-1:0] cnt_d [DEPTH];
    logic             wr_underflow_q;
    logic             wr_underflow_d;
    logic             wr_act;
    logic             same_reg;
    logic             rsv_acc;
    logic             pair;

    // Accept a reservation unless it would saturate; a same-cycle release nets to zero
    always_comb begin
        wr_act    = wr_en && (wr_addr != ZERO_A);
        same_reg  = wr_act && (rsv_addr == wr_addr);
        rsv_ready = !rst && ((rsv_addr == ZERO_A) || (cnt_q[rsv_addr] != CNT_MAX) || same_reg);
        rsv_acc   = rsv_en && rsv_ready && (rsv_addr != ZERO_A);
        pair      = rsv_acc && same_reg;
    end

    // Next counter state, sticky underflow, and busy view of the post-update counts
    always_comb begin
        cnt_d          = cnt_q;
        wr_underflow_d = wr_underflow_q;
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                cnt_d[r] = '0;
            end
            wr_underflow_d = 1'b0;
        end else begin
            if (rsv_acc && !pair) begin
                cnt_d[rsv_addr] = cnt_q[rsv_addr] + CNT_ONE;
            end
            if (wr_act && !pair && (cnt_q[wr_addr] != '0)) begin
                cnt_d[wr_addr] = cnt_q[wr_addr] - CNT_ONE;
            end
            if (wr_act && (cnt_q[wr_addr] == '0)) begin
                wr_underflow_d = 1'b1;
            end
        end
        for (int r = 0; r < DEPTH; r++) begin
            busy_next[r] = (cnt_d[r] != '0);
        end
    end

    // Counter and flag registers
    always_ff @(posedge clk) begin
        cnt_q          <= cnt_d;
        wr_underflow_q <= wr_underflow_d;
    end

    assign wr_underflow = wr_underflow_q;
endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - N-read register file with write-first bypass and write scoreboard
module regfile_scoreboard
    import rf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    regfile_scoreboard_if.slave  bus
);
    localparam int                DEPTH  = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0]        regs_q [DEPTH];
    logic [DATA_W-1:0]        regs_d [DEPTH];
    logic [NUM_RD*DATA_W-1:0] rd_data_q;
    logic [NUM_RD*DATA_W-1:0] rd_data_d;
    logic [NUM_RD-1:0]        rd_busy_q;
    logic [NUM_RD-1:0]        rd_busy_d;
    logic [DEPTH-1:0]         busy_next;
    logic                     wr_act;
    logic [ADDR_W-1:0]        a;

    reg_scoreboard #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_sb (
        .clk          (CLOCK),
        .rst          (RESET),
        .wr_en        (bus.wr_en),
        .wr_addr      (bus.wr_addr),
        .rsv_en       (bus.rsv_en),
        .rsv_addr     (bus.rsv_addr),
        .rsv_ready    (bus.rsv_ready),
        .wr_underflow (bus.wr_underflow),
        .busy_next    (busy_next)
    );

    // Data array update; register 0 is never written
    always_comb begin
        wr_act = bus.wr_en && (bus.wr_addr != ZERO_A);
        regs_d = regs_q;
        if (RESET) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_d[r] = '0;
            end
        end else if (wr_act) begin
            regs_d[bus.wr_addr] = bus.wr_data;
        end
    end

    // Per-port read mux with write-first bypass and post-update busy
    always_comb begin
        rd_data_d = '0;
        rd_busy_d = '0;
        a         = '0;
        if (!RESET) begin
            for (int i = 0; i < NUM_RD; i++) begin
                a = bus.rd_addr[i*ADDR_W +: ADDR_W];
                if (a != ZERO_A) begin
                    rd_data_d[i*DATA_W +: DATA_W] =
                        (wr_act && (bus.wr_addr == a)) ? bus.wr_data : regs_q[a];
                    rd_busy_d[i] = busy_next[a];
                end
            end
        end
    end

    // Array and read output registers
    always_ff @(posedge CLOCK) begin
        regs_q    <= regs_d;
        rd_data_q <= rd_data_d;
        rd_busy_q <= rd_busy_d;
    end

    assign bus.rd_data = rd_data_q;
    assign bus.rd_busy = rd_busy_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - vector table and scoreboard queue bench for regfile_scoreboard
module tb_regfile_scoreboard;
    logic CLOCK;
    logic RESET;

    regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus ();

    regfile_scoreboard #(
        .DATA_W (32),
        .ADDR_W (5),
        .NUM_RD (2),
        .CNT_W  (2)
    ) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    typedef struct {
        logic        rst;
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic [31:0] wr_data;
        logic        rsv_en;
        logic [4:0]  rsv_addr;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic        x_ready;
        logic [31:0] x_d0;
        logic [31:0] x_d1;
        logic        x_b0;
        logic        x_b1;
        logic        x_uf;
    } vec_t;

    typedef struct {
        string       tag;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        b0;
        logic        b1;
        logic        uf;
    } exp_t;

    vec_t tbl[$];
    exp_t expq[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic vec_t mk(
        input logic rst, input logic we, input logic [4:0] wa, input logic [31:0] wd,
        input logic re, input logic [4:0] ra, input logic [4:0] a0, input logic [4:0] a1,
        input logic xr, input logic [31:0] xd0, input logic [31:0] xd1,
        input logic xb0, input logic xb1, input logic xuf);
        vec_t v;
        v.rst = rst; v.wr_en = we; v.wr_addr = wa; v.wr_data = wd;
        v.rsv_en = re; v.rsv_addr = ra; v.a0 = a0; v.a1 = a1;
        v.x_ready = xr; v.x_d0 = xd0; v.x_d1 = xd1;
        v.x_b0 = xb0; v.x_b1 = xb1; v.x_uf = xuf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Drive one cycle of stimulus, check rsv_ready, queue expected read results, compare after the edge
    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        RESET        = v.rst;
        bus.wr_en    = v.wr_en;
        bus.wr_addr  = v.wr_addr;
        bus.wr_data  = v.wr_data;
        bus.rsv_en   = v.rsv_en;
        bus.rsv_addr = v.rsv_addr;
        bus.rd_addr  = {v.a1, v.a0};
        #1;
        chk({tag, " rsv_ready"}, {31'b0, bus.rsv_ready}, {31'b0, v.x_ready});
        e.tag = tag; e.d0 = v.x_d0; e.d1 = v.x_d1;
        e.b0 = v.x_b0; e.b1 = v.x_b1; e.uf = v.x_uf;
        expq.push_back(e);
        @(posedge CLOCK);
        #1;
        if (expq.size() == 0) begin
            n_chk++;
            $display("FAIL %s queue: got empty expected one entry", tag);
        end else begin
            e = expq.pop_front();
            chk({e.tag, " rd_data0"}, bus.rd_data[31:0], e.d0);
            chk({e.tag, " rd_data1"}, bus.rd_data[63:32], e.d1);
            chk({e.tag, " rd_busy0"}, {31'b0, bus.rd_busy[0]}, {31'b0, e.b0});
            chk({e.tag, " rd_busy1"}, {31'b0, bus.rd_busy[1]}, {31'b0, e.b1});
            chk({e.tag, " wr_underflow"}, {31'b0, bus.wr_underflow}, {31'b0, e.uf});
        end
    endtask

    initial begin
        logic [31:0] rnd;
        logic [4:0]  r;

        // reset, then read r5/r31
        tbl.push_back(mk(1, 0, 0, 0,             0, 0,  5, 31, 0, 0, 0, 0, 0, 0));
        // write/reserve r0 ignored
        tbl.push_back(mk(0, 1, 0, 32'hFFFFFFFF,  1, 0,  0,  5, 1, 0, 0, 0, 0, 0));
        // reserve r3, then bypassed write r3, then array read
        tbl.push_back(mk(0, 0, 0, 0,             1, 3,  3,  0, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 3, 32'hDEADBEEF,  0, 0,  3,  3, 1, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,             0, 0,  3,  0, 1, 32'hDEADBEEF, 0, 0, 0, 0));
        // RAW on r7
        tbl.push_back(mk(0, 0, 0, 0,             1, 7,  7,  3, 1, 0, 32'hDEADBEEF, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,             0, 0,  7,  7, 1, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 1, 7, 32'h12,        0, 0,  7,  3, 1, 32'h12, 32'hDEADBEEF, 0, 0, 0));
        // saturate r9: three accepted, fourth refused
        tbl.push_back(mk(0, 0, 0, 0,             1, 9,  9,  9, 1, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,             1, 9,  9,  9, 1, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,             1, 9,  9,  9, 1, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,             1, 9,  9,  9, 0, 0, 0, 1, 1, 0));
        // reserve+write r9 at saturation: accepted, count stays 3
        tbl.push_back(mk(0, 1, 9, 32'hA1,        1, 9,  9,  9, 1, 32'hA1, 32'hA1, 1, 1, 0));
        // three releases needed to clear busy
        tbl.push_back(mk(0, 1, 9, 32'hA2,        0, 0,  9,  9, 1, 32'hA2, 32'hA2, 1, 1, 0));
        tbl.push_back(mk(0, 1, 9, 32'hA3,        0, 0,  9,  9, 1, 32'hA3, 32'hA3, 1, 1, 0));
        tbl.push_back(mk(0, 1, 9, 32'hA4,        0, 0,  9,  9, 1, 32'hA4, 32'hA4, 0, 0, 0));
        // underflow on r4, sticky
        tbl.push_back(mk(0, 1, 4, 32'h44,        0, 0,  4,  9, 1, 32'h44, 32'hA4, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0,             0, 0,  4,  0, 1, 32'h44, 0, 0, 0, 1));
        // reset mid-operation with r2/r6 pending
        tbl.push_back(mk(0, 0, 0, 0,             1, 2,  2,  6, 1, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0,             1, 6,  2,  6, 1, 0, 0, 1, 1, 1));
        tbl.push_back(mk(1, 1, 4, 32'h55,        1, 6,  2,  6, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,             1, 2,  2,  4, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,             0, 0,  6,  9, 1, 0, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("v%0d", i));
        end

        // reserve, bypassed write, array read on a few registers with random data
        for (int k = 0; k < 4; k++) begin
            r   = 5'(20 + k);
            rnd = $urandom;
            apply(mk(0, 0, 0, 0,   1, r, r, 0, 1, 0, 0, 1, 0, 0), $sformatf("rsv%0d", k));
            apply(mk(0, 1, r, rnd, 0, 0, r, r, 1, rnd, rnd, 0, 0, 0), $sformatf("byp%0d", k));
            apply(mk(0, 0, 0, 0,   0, 0, 0, r, 1, 0, rnd, 0, 0, 0), $sformatf("arr%0d", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised register file for the pipelined CPU, with N registered read ports, one write port, write-first bypass and a per-register pending-write scoreboard. Issue reserves each destination register and writeback releases it, so the decode stage can detect RAW hazards from `rd_busy` without its own hazard tables. It replaces the fixed 2-read, 32×32 register file in the decode/writeback path.

## Interface
Parameters:
- `DATA_W`, default 32: register width.
- `ADDR_W`, default 5: address width; depth is 2**ADDR_W.
- `NUM_RD`, default 2: number of read ports, at least 1.
- `CNT_W`, default 2: pending-write counter width; maximum outstanding writes per register is 2**CNT_W-1.

Ports:
- `CLOCK`, in, 1: single clock, rising edge.
- `RESET`, in, 1: synchronous, active-high.
- `rd_addr`, in, NUM_RD*ADDR_W: read addresses; port i uses slice [i*ADDR_W +: ADDR_W].
- `rd_data`, out, NUM_RD*DATA_W: registered read data.
- `rd_busy`, out, NUM_RD: registered busy flag; 1 when the addressed register has pending writes.
- `wr_en`, in, 1: writeback strobe.
- `wr_addr`, in, ADDR_W: writeback destination.
- `wr_data`, in, DATA_W: writeback value.
- `rsv_en`, in, 1: reservation request from issue.
- `rsv_addr`, in, ADDR_W: register to reserve.
- `rsv_ready`, out, 1: combinational; 1 when a reservation on `rsv_addr` is accepted this cycle.
- `wr_underflow`, out, 1: sticky error flag; set by a write to a register whose count is 0.

## Operation
- Register 0:
  - Always reads 0 with busy 0.
  - Writes and reservations to address 0 are ignored; they never set `wr_underflow` and always see `rsv_ready`=1.
- Write, address != 0:
  - When `wr_en`, `regs[wr_addr]` <= `wr_data`.
  - If `cnt[wr_addr]`>0, the count decrements.
  - If `cnt[wr_addr]`=0, the count stays 0 and `wr_underflow` <= 1.
- Reservation:
  - `rsv_ready` = !RESET && (rsv_addr==0 || cnt[rsv_addr] != 2**CNT_W-1), with the increment and decrement net below applied.
  - A reservation is accepted when `rsv_en` && `rsv_ready`. Accepted and nonzero address: `cnt[rsv_addr]` increments.
  - If `rsv_en` is high and `rsv_ready` is low, nothing changes. Issue holds the request and retries.
- Same register reserved and written in one cycle: the count stays unchanged.
  - `rsv_ready` is 1 in this case even when the count is saturated, because the net change is zero.
- Reads, per port i, registered:
  - `rd_data[i]` <= (wr_en && wr_addr==rd_addr[i] && rd_addr[i]!=0) ? wr_data : regs[rd_addr[i]]. This is write-first bypass.
  - `rd_busy[i]` <= (cnt_next[rd_addr[i]] != 0), i.e. the count after this cycle's reserve and write updates.
- Counter arithmetic is unsigned CNT_W-bit and never wraps. Saturation is blocked by `rsv_ready`; underflow is blocked by the zero check.
- Every read port is independent. Any number of ports may share an address.

## Timing
- Read latency is 1 cycle: the address presented at edge k produces data and busy valid after edge k.
- A write at edge k is visible to a read issued in the same cycle, through the bypass. A read one cycle later gets it from the array.
- A reservation at edge k makes busy visible to a read issued in the same cycle.
- `RESET` high at an edge has priority over every other input. That edge forces:
  - all regs to 0,
  - all cnt to 0,
  - `rd_data` and `rd_busy` to 0,
  - `wr_underflow` to 0.
- `rsv_ready` is 0 while `RESET` is high.
- Reset mid-operation drops all outstanding reservations. The pipeline is flushed by the same reset.
- There is no initial-block reset; state is undefined until the first `RESET` edge.

## Structure
- Shared package `rf_pkg`: default DATA_W/ADDR_W/NUM_RD/CNT_W constants, the `REG_ZERO` address constant, and a `cnt_t` typedef.
- Sub-module `reg_scoreboard`:
  - Holds the counter array and the reserve/release/underflow logic.
  - Outputs `cnt_next` busy bits to the top, and `rsv_ready`.
- The top holds the data array, bypass muxes and output registers.

## Test plan
- Reset then read: RESET 1 cycle, read r5 and r31 on both ports -> rd_data=0, rd_busy=0, wr_underflow=0.
- Bypass: write r3=0xDEADBEEF while port0 reads r3 -> next cycle rd_data0=0xDEADBEEF. Same write to r0 -> rd_data reads 0 and wr_underflow stays 0.
- Scoreboard RAW:
  - Reserve r7 and read r7 -> rd_busy0=1 while the write is pending.
  - Write r7=0x12 -> same-cycle read shows data 0x12, busy 0.
- Saturation with CNT_W=2:
  - Reserve r9 three times -> rsv_ready=0 on the fourth attempt and the count stays 3.
  - Same cycle: reserve and write r9 -> rsv_ready=1 and the count stays 3.
  - Three more writes -> busy clears.
- Underflow: write r4 with no reservation -> data written, wr_underflow=1 and sticky until RESET.
- Reset mid-operation: reserve r2 and r6, RESET -> busy 0 for both, regs 0. The next reserve on r2 is accepted.
